// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: PC generation, credit-limited imem requests, in-order prefetch queue to decode.
// Define IFQ_PERF_CNT_EN to enable the bubble_cnt decode-starvation counter.
module instr_fetch_queue #(
  parameter int INSTR_W = 38,
  parameter int ADDR_W = 24,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 24'h000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       imem_req_valid,
  output logic [ADDR_W-1:0]          imem_req_addr,
  input  logic                       imem_req_ready,
  input  logic                       imem_rsp_valid,
  input  logic [INSTR_W-1:0]         imem_rsp_data,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  input  logic                       id_stall,
  output logic                       id_valid,
  output logic [INSTR_W-1:0]         id_instr,
  output logic [ADDR_W-1:0]          id_pc,
  output logic [$clog2(DEPTH):0]     q_count,
  output logic [15:0]                bubble_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {FETCH, FLUSH} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d, out_q, out_d, drop_q, drop_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, trd_q, twr_q;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, id_pc_q, id_pc_d, rsp_pc;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [INSTR_W-1:0] iq_instr [DEPTH];
  logic [ADDR_W-1:0] iq_pc [DEPTH];
  logic [ADDR_W-1:0] tag [DEPTH];
  logic req, acc, push, pop;
  always_comb begin
    req = rst_n && state_q == FETCH && !redirect_valid &&
          ({1'b0, count_q} + {1'b0, out_q} < (CW+1)'(DEPTH));
    acc = req && imem_req_ready;
    push = imem_rsp_valid && drop_q == '0 && !redirect_valid;
    pop = count_q != '0 && !id_stall && !redirect_valid;
    rsp_pc = tag[trd_q];
    count_d = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
    out_d = out_q + CW'(acc) - CW'(imem_rsp_valid);
    // In FLUSH no requests issue, so outstanding and drop_cnt track each other
    drop_d = redirect_valid ? out_q - CW'(imem_rsp_valid)
                            : drop_q - CW'(imem_rsp_valid && drop_q != '0);
    state_d = drop_d != '0 ? FLUSH : FETCH;
    fetch_pc_d = redirect_valid ? redirect_pc : fetch_pc_q + ADDR_W'(acc);
    rd_d = redirect_valid ? wr_q : rd_q + PW'(pop);
    wr_d = wr_q + PW'(push);
    id_instr_d = id_instr_q;
    id_pc_d = id_pc_q;
    if (count_d != '0) begin
      id_instr_d = count_q == CW'(pop) ? imem_rsp_data : iq_instr[rd_d];
      id_pc_d = count_q == CW'(pop) ? rsp_pc : iq_pc[rd_d];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      fetch_pc_q <= RESET_PC;
      count_q <= '0;
      out_q <= '0;
      drop_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      trd_q <= '0;
      twr_q <= '0;
      id_instr_q <= '0;
      id_pc_q <= '0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q <= count_d;
      out_q <= out_d;
      drop_q <= drop_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      trd_q <= trd_q + PW'(imem_rsp_valid);
      twr_q <= twr_q + PW'(acc);
      id_instr_q <= id_instr_d;
      id_pc_q <= id_pc_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      iq_instr[wr_q] <= imem_rsp_data;
      iq_pc[wr_q] <= rsp_pc;
    end
    if (acc) tag[twr_q] <= fetch_pc_q;
  end
  assign imem_req_valid = req;
  assign imem_req_addr = fetch_pc_q;
  assign id_valid = count_q != '0;
  assign id_instr = id_instr_q;
  assign id_pc = id_pc_q;
  assign q_count = count_q;
`ifdef IFQ_PERF_CNT_EN
  logic [15:0] bub_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bub_q <= '0;
    else if (count_q == '0 && !id_stall && bub_q != 16'hFFFF) bub_q <= bub_q + 16'd1;
  end
  assign bubble_cnt = bub_q;
`else
  assign bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed checks of fetch sequencing, stall, flush, redirect and wrap.
module tb_instr_fetch_queue;
  logic clk = 0, rst_n = 1, rdy = 1;
  logic imem_req_valid, imem_rsp_valid = 0, redirect_valid = 0, id_stall = 0, id_valid;
  logic [23:0] imem_req_addr, redirect_pc = 0, id_pc;
  logic [37:0] imem_rsp_data = 0, id_instr;
  logic [2:0] q_count;
  logic [15:0] bubble_cnt;
  int total = 0, bad = 0, cyc = 0, lat = 1;
  bit hold = 0;
  logic [23:0] mq_addr[$];
  int mq_due[$];

  instr_fetch_queue dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(rdy),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_stall(id_stall),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .q_count(q_count), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] mdata(input logic [23:0] a);
    return {a[13:0] ^ 14'h1555, a};
  endfunction

  // In-order memory model: response appears lat cycles after acceptance
  always @(posedge clk) begin
    if (!rst_n) begin
      mq_addr.delete();
      mq_due.delete();
    end else begin
      if (imem_rsp_valid) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (imem_req_valid && rdy) begin
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(cyc + lat);
      end
    end
    cyc++;
    #1;
    if (rst_n && !hold && mq_due.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1;
      imem_rsp_data = mdata(mq_addr[0]);
    end else begin
      imem_rsp_valid = 0;
      imem_rsp_data = 0;
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; redirect_valid = 0; id_stall = 0; hold = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    lat = 1;
    @(negedge clk);
    rst_n = 0;
    #1;
    total += 7;
    if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%0h exp=0", imem_req_valid); end
    if (imem_req_addr !== 24'h0) begin bad++; $display("FAIL rst_req_addr got=%0h exp=0", imem_req_addr); end
    if (id_valid !== 1'b0) begin bad++; $display("FAIL rst_id_valid got=%0h exp=0", id_valid); end
    if (id_instr !== 38'h0) begin bad++; $display("FAIL rst_id_instr got=%0h exp=0", id_instr); end
    if (id_pc !== 24'h0) begin bad++; $display("FAIL rst_id_pc got=%0h exp=0", id_pc); end
    if (q_count !== 3'd0) begin bad++; $display("FAIL rst_q_count got=%0h exp=0", q_count); end
    if (bubble_cnt !== 16'd0) begin bad++; $display("FAIL rst_bubble got=%0h exp=0", bubble_cnt); end
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_sequential();
    lat = 1;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total += 2;
      if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL seq_req_valid i=%0d got=%0h exp=1", i, imem_req_valid); end
      if (imem_req_addr !== 24'(i + 1)) begin bad++; $display("FAIL seq_req_addr i=%0d got=%0h exp=%0h", i, imem_req_addr, i + 1); end
      if (i == 0) begin
        total++;
        if (id_valid !== 1'b0) begin bad++; $display("FAIL seq_first_valid got=%0h exp=0", id_valid); end
      end else begin
        total += 3;
        if (id_valid !== 1'b1) begin bad++; $display("FAIL seq_valid i=%0d got=%0h exp=1", i, id_valid); end
        if (id_pc !== 24'(i - 1)) begin bad++; $display("FAIL seq_pc i=%0d got=%0h exp=%0h", i, id_pc, i - 1); end
        if (id_instr !== mdata(24'(i - 1))) begin bad++; $display("FAIL seq_instr i=%0d got=%0h exp=%0h", i, id_instr, mdata(24'(i - 1))); end
      end
    end
  endtask

  task automatic test_stall();
    id_stall = 1;
    repeat (10) @(negedge clk);
    total += 4;
    if (q_count !== 3'd4) begin bad++; $display("FAIL stall_count got=%0d exp=4", q_count); end
    if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_req_valid got=%0h exp=0", imem_req_valid); end
    if (id_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%0h exp=1", id_valid); end
    if (id_pc !== 24'd10) begin bad++; $display("FAIL stall_pc got=%0h exp=a", id_pc); end
    id_stall = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      total += 2;
      if (id_valid !== 1'b1) begin bad++; $display("FAIL stall_rel_valid j=%0d got=%0h exp=1", j, id_valid); end
      if (id_pc !== 24'(11 + j)) begin bad++; $display("FAIL stall_rel_pc j=%0d got=%0h exp=%0h", j, id_pc, 11 + j); end
    end
  endtask

  task automatic test_flush();
    bit seen = 0;
    lat = 4;
    do_reset();
    repeat (3) @(negedge clk);
    redirect_valid = 1; redirect_pc = 24'h000100;
    #1;
    total++;
    if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL flush_redir_req got=%0h exp=0", imem_req_valid); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) redirect_valid = 0;
      total += 3;
      if (id_valid !== 1'b0) begin bad++; $display("FAIL flush_valid k=%0d got=%0h exp=0", k, id_valid); end
      if (q_count !== 3'd0) begin bad++; $display("FAIL flush_count k=%0d got=%0d exp=0", k, q_count); end
      if (imem_req_valid !== (k == 3)) begin bad++; $display("FAIL flush_req_valid k=%0d got=%0h exp=%0h", k, imem_req_valid, k == 3); end
    end
    total++;
    if (imem_req_addr !== 24'h000100) begin bad++; $display("FAIL flush_req_addr got=%0h exp=100", imem_req_addr); end
    for (int w = 0; w < 20 && !seen; w++) begin
      @(negedge clk);
      seen = id_valid;
    end
    total += 3;
    if (!seen) begin bad++; $display("FAIL flush_wait got=0 exp=1"); end
    if (id_pc !== 24'h000100) begin bad++; $display("FAIL flush_pc got=%0h exp=100", id_pc); end
    if (id_instr !== mdata(24'h000100)) begin bad++; $display("FAIL flush_instr got=%0h exp=%0h", id_instr, mdata(24'h000100)); end
  endtask

  task automatic test_redirect_rsp();
    lat = 1;
    do_reset();
    repeat (5) @(negedge clk);
    redirect_valid = 1; redirect_pc = 24'h000200;
    #1;
    total++;
    if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rr_req_same got=%0h exp=0", imem_req_valid); end
    @(negedge clk);
    redirect_valid = 0;
    #1;
    total += 4;
    if (id_valid !== 1'b0) begin bad++; $display("FAIL rr_valid got=%0h exp=0", id_valid); end
    if (q_count !== 3'd0) begin bad++; $display("FAIL rr_count got=%0d exp=0", q_count); end
    if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL rr_req_valid got=%0h exp=1", imem_req_valid); end
    if (imem_req_addr !== 24'h000200) begin bad++; $display("FAIL rr_req_addr got=%0h exp=200", imem_req_addr); end
    @(negedge clk);
    total++;
    if (id_valid !== 1'b0) begin bad++; $display("FAIL rr_valid2 got=%0h exp=0", id_valid); end
    @(negedge clk);
    total += 2;
    if (id_valid !== 1'b1) begin bad++; $display("FAIL rr_valid3 got=%0h exp=1", id_valid); end
    if (id_pc !== 24'h000200) begin bad++; $display("FAIL rr_pc got=%0h exp=200", id_pc); end
  endtask

  task automatic test_wrap();
    logic [23:0] exp_pc = 24'hFFFFFE;
    bit seen = 0;
    redirect_valid = 1; redirect_pc = 24'hFFFFFE;
    for (int w = 0; w < 20 && !seen; w++) begin
      @(negedge clk);
      redirect_valid = 0;
      seen = id_valid;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL wrap_wait got=0 exp=1"); end
    for (int j = 0; j < 4; j++) begin
      if (j > 0) @(negedge clk);
      total++;
      if (id_pc !== exp_pc) begin bad++; $display("FAIL wrap_pc j=%0d got=%0h exp=%0h", j, id_pc, exp_pc); end
      exp_pc = exp_pc + 24'd1;
    end
  endtask

  task automatic test_bubble();
    bit seen = 0;
    lat = 1;
    do_reset();
    hold = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
`ifndef IFQ_PERF_CNT_EN
      total++;
      if (bubble_cnt !== 16'd0) begin bad++; $display("FAIL bubble_zero i=%0d got=%0h exp=0", i, bubble_cnt); end
`endif
    end
    total += 2;
    if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL bubble_credit got=%0h exp=0", imem_req_valid); end
`ifdef IFQ_PERF_CNT_EN
    if (!(bubble_cnt >= 16'd20)) begin bad++; $display("FAIL bubble_cnt got=%0d exp>=20", bubble_cnt); end
`else
    if (bubble_cnt !== 16'd0) begin bad++; $display("FAIL bubble_cnt got=%0d exp=0", bubble_cnt); end
`endif
    hold = 0;
    for (int w = 0; w < 20 && !seen; w++) begin
      @(negedge clk);
      seen = id_valid;
    end
    total += 2;
    if (!seen) begin bad++; $display("FAIL bubble_wait got=0 exp=1"); end
    if (id_pc !== 24'h0) begin bad++; $display("FAIL bubble_pc got=%0h exp=0", id_pc); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_flush();
    test_redirect_rsp();
    test_wrap();
    test_bubble();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
